// File: rtl/bus_arb_mux_if.sv
// bus_arb_mux_if: the handshake and data bundle between a set of producer channels, the
// bus_arb_mux selector and a single downstream consumer.
//
// Signals:
//   mode     1 = round-robin arbitration, 0 = direct select by sel
//   sel      channel index used in direct mode
//   req      per-channel "data offered" flags
//   din      packed channel data; channel k sits in din[k*WIDTH +: WIDTH]
//   grant    one-hot, one-cycle acknowledge to the channel that was captured
//   q        registered selected data
//   q_ch     index of the channel that produced q
//   q_valid  q/q_ch hold an unconsumed word
//   q_ready  consumer accepts q this cycle
//
// Modports:
//   master   the environment side (producers and consumer)
//   slave    the bus_arb_mux side
interface bus_arb_mux_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = 3
) ();

    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS-1:0]       req;
    logic [CHANNELS*WIDTH-1:0] din;
    logic [CHANNELS-1:0]       grant;
    logic [WIDTH-1:0]          q;
    logic [SEL_W-1:0]          q_ch;
    logic                      q_valid;
    logic                      q_ready;

    modport master (
        output mode,
        output sel,
        output req,
        output din,
        output q_ready,
        input  grant,
        input  q,
        input  q_ch,
        input  q_valid
    );

    modport slave (
        input  mode,
        input  sel,
        input  req,
        input  din,
        input  q_ready,
        output grant,
        output q,
        output q_ch,
        output q_valid
    );

endinterface

// File: rtl/bus_arb_mux.sv
// bus_arb_mux: selects one of CHANNELS data channels into a one-entry output register.
//
// The source is chosen either directly (mode=0, channel sel) or by round-robin arbitration
// (mode=1, search starts just above the last loaded channel). A word is loaded whenever the
// output register is empty or is being consumed this cycle, so back-to-back transfers run at
// one word per cycle. The captured channel receives a one-cycle grant pulse the cycle after
// its data was sampled.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    bus_arb_mux_if.slave: mode, sel, req, din, q_ready in; grant, q, q_ch, q_valid out
module bus_arb_mux #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = 3
) (
    input logic          clk,
    input logic          reset,
    bus_arb_mux_if.slave bus
);

    // Elaboration-time parameter sanity checks.
    if (SEL_W != $clog2(CHANNELS)) begin : g_sel_w_check
        $error("bus_arb_mux: SEL_W must equal clog2(CHANNELS)");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
        $error("bus_arb_mux: WIDTH must be in 1..32");
    end
    if (CHANNELS < 2 || CHANNELS > 16) begin : g_channels_check
        $error("bus_arb_mux: CHANNELS must be in 2..16");
    end

    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } state_e;

    // Registered state and outputs.
    state_e              state_q;
    logic [WIDTH-1:0]    q_q;
    logic [SEL_W-1:0]    q_ch_q;
    logic [CHANNELS-1:0] grant_q;
    // Last loaded channel; round-robin search begins one above it.
    logic [SEL_W-1:0]    ptr_q;

    // Unpacked view of the channel data.
    logic [WIDTH-1:0] din_ch [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
        assign din_ch[g] = bus.din[g*WIDTH +: WIDTH];
    end

    // ------------------------------------------------------------------
    // Direct select
    // ------------------------------------------------------------------
    logic dir_in_range;
    logic dir_found;

    // With a power-of-two channel count every sel value names a real channel.
    if (CHANNELS == (1 << SEL_W)) begin : g_sel_full_range
        assign dir_in_range = 1'b1;
    end else begin : g_sel_part_range
        assign dir_in_range = (32'(bus.sel) < CHANNELS);
    end

    assign dir_found = dir_in_range & bus.req[bus.sel];

    // ------------------------------------------------------------------
    // Round-robin search: first requester at ptr+1, ptr+2, ... wrapping, ending at ptr itself.
    // ------------------------------------------------------------------
    logic             rr_found;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] rr_cand;

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            rr_cand = SEL_W'((32'(ptr_q) + i) % CHANNELS);
            if (!rr_found && bus.req[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Winner and load decision
    // ------------------------------------------------------------------
    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    logic             load_opp;

    assign win_found = bus.mode ? rr_found : dir_found;
    assign win_idx   = bus.mode ? rr_idx   : bus.sel;

    // q_ready only matters while a word is held.
    assign load_opp  = (state_q == StEmpty) || bus.q_ready;

    // ------------------------------------------------------------------
    // Output register FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            q_q     <= '0;
            q_ch_q  <= '0;
            grant_q <= '0;
            // Park the pointer on the top channel so channel 0 wins first after reset.
            ptr_q   <= SEL_W'(CHANNELS - 1);
        end else begin
            // grant is a single-cycle pulse; it is raised only on a load.
            grant_q <= '0;
            if (load_opp) begin
                if (win_found) begin
                    state_q <= StFull;
                    q_q     <= din_ch[win_idx];
                    q_ch_q  <= win_idx;
                    grant_q <= {{(CHANNELS-1){1'b0}}, 1'b1} << win_idx;
                    ptr_q   <= win_idx;
                end else begin
                    // Nothing to load: drop valid, keep the stale data/index visible.
                    state_q <= StEmpty;
                end
            end
        end
    end

    assign bus.q       = q_q;
    assign bus.q_ch    = q_ch_q;
    assign bus.q_valid = (state_q == StFull);
    assign bus.grant   = grant_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Self-checking bench for bus_arb_mux. A behavioural model (one-entry buffer plus a
// last-winner pointer, winner found by a modular search) predicts every output cycle.
module tb_bus_arb_mux;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 8;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned OW       = WIDTH + SEL_W + 1 + CHANNELS;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bus_arb_mux_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus ();

    bus_arb_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state.
    logic [WIDTH-1:0]    exp_q;
    logic [SEL_W-1:0]    exp_ch;
    logic                exp_valid;
    logic [CHANNELS-1:0] exp_grant;
    int                  m_ptr;

    function automatic logic [OW-1:0] outs();
        return {bus.q, bus.q_ch, bus.q_valid, bus.grant};
    endfunction

    function automatic logic [OW-1:0] exps();
        return {exp_q, exp_ch, exp_valid, exp_grant};
    endfunction

    function automatic bit req_bit(input logic [CHANNELS-1:0] r, input int c);
        logic [CHANNELS-1:0] t;
        t = r >> c;
        return t[0];
    endfunction

    // Returns the winning channel for the current inputs, or -1 for none.
    function automatic int find_winner();
        if (!bus.mode) begin
            if (int'(bus.sel) < CHANNELS && req_bit(bus.req, int'(bus.sel)))
                return int'(bus.sel);
            return -1;
        end
        for (int off = 1; off <= CHANNELS; off++) begin
            int c;
            c = (m_ptr + off) % CHANNELS;
            if (req_bit(bus.req, c)) return c;
        end
        return -1;
    endfunction

    // Advance one clock and update the model from the inputs sampled at that edge.
    task automatic tick();
        int                        w;
        bit                        opp;
        logic [CHANNELS*WIDTH-1:0] d;
        opp = !exp_valid || bus.q_ready;
        w   = find_winner();
        d   = bus.din;
        @(posedge clk);
        if (reset) begin
            exp_q     = '0;
            exp_ch    = '0;
            exp_valid = 1'b0;
            exp_grant = '0;
            m_ptr     = CHANNELS - 1;
        end else begin
            exp_grant = '0;
            if (opp) begin
                if (w >= 0) begin
                    d         = d >> (w * WIDTH);
                    exp_q     = d[WIDTH-1:0];
                    exp_ch    = SEL_W'(w);
                    exp_valid = 1'b1;
                    exp_grant = CHANNELS'(1) << w;
                    m_ptr     = w;
                end else begin
                    exp_valid = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic rand_din();
        bus.din = {$urandom(), $urandom()};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.mode    = 1'b1;
        bus.sel     = '0;
        bus.req     = 8'hFF;
        bus.q_ready = 1'b0;
        rand_din();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (outs() !== {{WIDTH{1'b0}}, {SEL_W{1'b0}}, 1'b0, {CHANNELS{1'b0}}}) begin
                errors++;
                $display("FAIL reset[%0d]: got %h, required all zero", i, outs());
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_direct();
        // Channel 5 offers A5 under direct select.
        bus.mode    = 1'b0;
        bus.sel     = 3'd5;
        bus.req     = 8'h20;
        bus.q_ready = 1'b1;
        rand_din();
        bus.din[5*WIDTH +: WIDTH] = 8'hA5;
        tick();
        checks++;
        if (outs() !== {8'hA5, 3'd5, 1'b1, 8'h20}) begin
            errors++;
            $display("FAIL direct_ch5: got %h, required %h", outs(), {8'hA5, 3'd5, 1'b1, 8'h20});
        end
        // Selected channel not requesting: the held word drains and nothing new loads.
        bus.sel = 3'd3;
        bus.req = 8'hF7;
        for (int i = 0; i < 2; i++) begin
            rand_din();
            tick();
            checks++;
            if (bus.q_valid !== 1'b0 || bus.grant !== '0 || outs() !== exps()) begin
                errors++;
                $display("FAIL direct_noreq[%0d]: got %h, required %h", i, outs(), exps());
            end
        end
    endtask

    task automatic test_rr_sweep();
        do_reset();
        bus.mode    = 1'b1;
        bus.req     = 8'hFF;
        bus.q_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rand_din();
            tick();
            checks++;
            if (bus.q_ch !== SEL_W'(i % CHANNELS) || bus.q_valid !== 1'b1 ||
                outs() !== exps()) begin
                errors++;
                $display("FAIL rr_sweep[%0d]: got ch=%0d v=%b (%h), required ch=%0d v=1 (%h)",
                         i, bus.q_ch, bus.q_valid, outs(), i % CHANNELS, exps());
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] held_q;
        bus.mode    = 1'b0;
        bus.sel     = 3'd2;
        bus.req     = 8'h04;
        bus.q_ready = 1'b1;
        rand_din();
        held_q = bus.din[2*WIDTH +: WIDTH];
        tick();
        bus.q_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mode = 1'($urandom());
            bus.sel  = SEL_W'($urandom());
            bus.req  = CHANNELS'($urandom()) | 8'h01;
            rand_din();
            tick();
            checks++;
            if (bus.q !== held_q || bus.q_ch !== 3'd2 || bus.q_valid !== 1'b1 ||
                bus.grant !== '0 || outs() !== exps()) begin
                errors++;
                $display("FAIL backpressure[%0d]: got %h, required q=%h ch=2 v=1 g=0",
                         i, outs(), held_q);
            end
        end
        // Release: ptr is 2, so round-robin with all requesting picks channel 3 at once.
        bus.q_ready = 1'b1;
        bus.mode    = 1'b1;
        bus.req     = 8'hFF;
        rand_din();
        tick();
        checks++;
        if (bus.q_ch !== 3'd3 || bus.grant !== 8'h08 || bus.q_valid !== 1'b1 ||
            outs() !== exps()) begin
            errors++;
            $display("FAIL backpressure_release: got %h, required ch=3 g=08 (%h)", outs(), exps());
        end
    endtask

    task automatic test_rr_wrap();
        int exp_seq [3] = '{0, 7, 0};
        do_reset();
        bus.mode    = 1'b1;
        bus.req     = 8'h81;
        bus.q_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_din();
            tick();
            checks++;
            if (bus.q_ch !== SEL_W'(exp_seq[i]) || bus.q_valid !== 1'b1 || outs() !== exps()) begin
                errors++;
                $display("FAIL rr_wrap[%0d]: got ch=%0d (%h), required ch=%0d (%h)",
                         i, bus.q_ch, outs(), exp_seq[i], exps());
            end
        end
        bus.req = '0;
        tick();
        checks++;
        if (bus.q_valid !== 1'b0 || bus.grant !== '0 || outs() !== exps()) begin
            errors++;
            $display("FAIL rr_drain: got v=%b g=%b, required v=0 g=0", bus.q_valid, bus.grant);
        end
    endtask

    task automatic test_reset_full();
        bus.mode    = 1'b1;
        bus.req     = 8'h10;
        bus.q_ready = 1'b1;
        rand_din();
        tick();
        bus.q_ready = 1'b0;
        bus.req     = 8'hFF;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.q !== '0 || bus.q_valid !== 1'b0 || bus.grant !== '0 || bus.q_ch !== '0) begin
            errors++;
            $display("FAIL reset_full: got %h, required all zero", outs());
        end
        rand_din();
        tick();
        checks++;
        if (bus.q_ch !== 3'd0 || bus.q_valid !== 1'b1 || bus.grant !== 8'h01 ||
            outs() !== exps()) begin
            errors++;
            $display("FAIL reset_first_rr: got %h, required ch=0 v=1 g=01 (%h)", outs(), exps());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 49) == 0);
            bus.q_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) bus.mode = ~bus.mode;
            bus.sel = SEL_W'($urandom());
            case ($urandom_range(0, 3))
                0:       bus.req = '0;
                1:       bus.req = CHANNELS'(1) << $urandom_range(0, CHANNELS - 1);
                default: bus.req = CHANNELS'($urandom());
            endcase
            rand_din();
            tick();
            checks++;
            if (outs() !== exps() || $countones(bus.grant) > 1) begin
                errors++;
                $display("FAIL random[%0d]: got %h, required %h", i, outs(), exps());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.mode    = 1'b0;
        bus.sel     = '0;
        bus.req     = '0;
        bus.din     = '0;
        bus.q_ready = 1'b0;
        exp_valid   = 1'b0;
        m_ptr       = CHANNELS - 1;
        test_reset();
        test_direct();
        test_rr_sweep();
        test_backpressure();
        test_rr_wrap();
        test_reset_full();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arb_mux.md
BUS_ARB_MUX -- requirements
Module: bus_arb_mux

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data bit width per channel (legal 1..32).
REQ-002 Parameter CHANNELS, default 8, SHALL set the number of input channels (legal 2..16).
REQ-003 Parameter SEL_W, default 3, SHALL set the select/channel-index width and SHALL equal ceil(log2(CHANNELS)).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 mode  input  1  SHALL select the source policy: 0 = direct select, 1 = round-robin arbitration.
REQ-007 sel  input  SEL_W  SHALL give the channel index used in direct mode.
REQ-008 req  input  CHANNELS  SHALL flag, per channel, that its data is offered.
REQ-009 din  input  CHANNELS*WIDTH  SHALL carry packed channel data; channel k occupies bits k*WIDTH+WIDTH-1 down to k*WIDTH.
REQ-010 grant  output  CHANNELS  SHALL be a one-hot, one-cycle acknowledge to the channel whose data was captured.
REQ-011 q  output  WIDTH  SHALL be the registered selected data.
REQ-012 q_ch  output  SEL_W  SHALL be the index of the channel that produced q.
REQ-013 q_valid  output  1  SHALL indicate that q and q_ch hold an unconsumed word.
REQ-014 q_ready  input  1  SHALL indicate that the consumer accepts q this cycle.

Function
REQ-015 The block SHALL implement a one-entry output register with two states: EMPTY (q_valid=0) and FULL (q_valid=1).
REQ-016 A load opportunity SHALL exist in a cycle when state is EMPTY, or when state is FULL and q_ready=1.
REQ-017 Direct mode: the winner SHALL be channel sel when sel < CHANNELS and req[sel]=1; otherwise there is no winner.
REQ-018 Round-robin mode: the winner SHALL be the first channel with req=1, searching from index ptr+1 upward and wrapping modulo CHANNELS; if req is all zero, there is no winner.
REQ-019 On a load opportunity with a winner, the block SHALL register q=din[winner], q_ch=winner, q_valid=1, and assert grant[winner] for exactly the following cycle.
REQ-020 ptr SHALL update to the winner on every load in either mode and SHALL otherwise hold.
REQ-021 On a load opportunity without a winner, the block SHALL clear q_valid to 0 and go EMPTY; q and q_ch SHALL hold their last values.
REQ-022 In FULL with q_ready=0, q, q_ch and q_valid SHALL hold, grant SHALL be all zero, and req/sel/mode changes SHALL have no effect.
REQ-023 Latency SHALL be one cycle from the sampling edge to q_valid and grant.
REQ-024 Accept and reload in the same cycle (FULL, q_ready=1, winner present) SHALL sustain one word per cycle with no bubble.
REQ-025 q_ready while EMPTY SHALL be ignored.
REQ-026 grant SHALL never have more than one bit set and SHALL be zero in any cycle following a cycle with no load.
REQ-027 A mode change SHALL take effect at the next load opportunity; ptr SHALL NOT reset on a mode change.

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL set q=0, q_ch=0, q_valid=0, grant=0, ptr=CHANNELS-1, and state EMPTY, overriding any load.
REQ-029 Reset asserted while FULL SHALL discard the held word without asserting grant.
REQ-030 On the first edge after reset deassertion, round-robin SHALL give channel 0 the highest priority.

Verification
REQ-031 Direct mode, with default parameters: sel=5, req=8'h20, din ch5=8'hA5, q_ready=1 -> on the next cycle q=8'hA5, q_ch=5, q_valid=1, grant=8'h20.
REQ-032 Direct mode with sel=3 and req=8'hF7 (req[3]=0) -> q_valid stays 0 and grant stays 0.
REQ-033 Round-robin after reset, with req=8'hFF and q_ready=1 held -> q_ch sequence 0,1,...,7,0 on consecutive cycles, with q_valid continuously 1.
REQ-034 Backpressure: FULL with q_ch=2, q_ready=0 for 4 cycles while req and din change -> q and q_ch stay constant and grant stays 0; after q_ready=1, the next winner loads in the same cycle.
REQ-035 Round-robin with req=8'h81, ptr=7 -> the winner is 0, then 7, then 0; with req=0 and q_ready=1 -> q_valid drops to 0 in one cycle.
REQ-036 Reset asserted while FULL with q_ready=0 -> on the next cycle q=0, q_valid=0, grant=0; the first round-robin load after reset selects channel 0 when req=8'hFF.
